// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// The parity definition must stay identical to the one the receiver uses.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that buffers bus writes ahead of the serialiser.
// Pushes are dropped while full and pops are ignored while empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               push_i,
    input  logic [UART_DATA_W-1:0]             data_i,
    input  logic                               pop_i,
    output logic [UART_DATA_W-1:0]             data_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [UART_DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   do_push, do_pop;

    assign full_o  = (count_q == CntW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(do_push);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_master.sv
// UART transmitter: buffers bus bytes and serialises start, 8 data bits LSB first,
// even-sum parity and stop bit(s), chaining frames back to back while data is queued.
module uart_master
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                               clk_tx,
    input  logic                               rst_tx_n,
    input  logic                               en_tx,
    input  logic [UART_DATA_W-1:0]             tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               u_tx,
    output logic                               u_tx_busy,
    output logic                               u_tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned StopCycles = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned BaudW      = $clog2(StopCycles + 1);
    localparam logic [BaudW-1:0] BitLast  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] StopLast = BaudW'(StopCycles - 1);

    uart_state_e            state_q, state_d;
    logic [BaudW-1:0]       baud_q, baud_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;

    logic                   fifo_full, fifo_empty, fifo_pop;
    logic [UART_DATA_W-1:0] fifo_head;
    logic                   can_start, bit_end, stop_end;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_tx),
        .rst_ni  (rst_tx_n),
        .push_i  (tx_valid),
        .data_i  (tx_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign tx_ready  = !fifo_full;
    assign u_tx      = tx_q;
    assign u_tx_busy = (state_q != IDLE);
    assign u_tx_done = done_q;

    assign can_start = !fifo_empty && en_tx;
    assign bit_end   = (baud_q == BitLast);
    // The stop phase reuses the baud counter across all stop bits as one long interval.
    assign stop_end  = (baud_q == StopLast);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (can_start) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    parity_d = uart_parity(fifo_head);
                    baud_d   = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                        tx_d    = parity_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            STOP: begin
                if (stop_end) begin
                    done_d = 1'b1;
                    baud_d = '0;
                    if (can_start) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        parity_d = uart_parity(fifo_head);
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_tx) begin
        if (!rst_tx_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_master.sv
// Directed bench for uart_master: default instance plus a slow-baud, two-stop-bit instance.
module tb_uart_master;

    logic       clk_tx = 1'b0;
    logic       rst_tx_n;
    logic       en_tx, tx_valid, tx_ready, u_tx, u_tx_busy, u_tx_done;
    logic [7:0] tx_data;
    logic [2:0] fifo_count;

    logic       s_en, s_valid, s_ready, s_tx, s_busy, s_done;
    logic [7:0] s_data;
    logic [2:0] s_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] full_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [2:0] full_cnt   [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       full_rdy   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk_tx = ~clk_tx;

    uart_master dut (
        .clk_tx     (clk_tx),
        .rst_tx_n   (rst_tx_n),
        .en_tx      (en_tx),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .u_tx       (u_tx),
        .u_tx_busy  (u_tx_busy),
        .u_tx_done  (u_tx_done),
        .fifo_count (fifo_count)
    );

    uart_master #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4),
        .STOP_BITS    (2)
    ) dut_slow (
        .clk_tx     (clk_tx),
        .rst_tx_n   (rst_tx_n),
        .en_tx      (s_en),
        .tx_data    (s_data),
        .tx_valid   (s_valid),
        .tx_ready   (s_ready),
        .u_tx       (s_tx),
        .u_tx_busy  (s_busy),
        .u_tx_done  (s_done),
        .fifo_count (s_count)
    );

    task automatic test_reset();
        rst_tx_n = 1'b0;
        en_tx    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        s_en     = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        repeat (2) @(posedge clk_tx);
        #1;
        total++; if (u_tx !== 1'b1) begin bad++; $display("FAIL reset_u_tx got=%b want=1", u_tx); end
        total++; if (u_tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", u_tx_busy); end
        total++; if (u_tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", u_tx_done); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
        total++; if (s_tx !== 1'b1) begin bad++; $display("FAIL reset_slow_u_tx got=%b want=1", s_tx); end
        rst_tx_n = 1'b1;
        @(posedge clk_tx);
        #1;
    endtask

    task automatic test_single_byte();
        logic [10:0] exp;
        int          dones;
        exp   = {1'b1, 1'b0, 8'hA5, 1'b0};
        dones = 0;
        en_tx    = 1'b1;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk_tx); #1;
        tx_valid = 1'b0;
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_queued got=%0d want=1", fifo_count); end
        total++; if (u_tx !== 1'b1) begin bad++; $display("FAIL single_pre_idle got=%b want=1", u_tx); end
        for (int i = 0; i < 11; i++) begin
            @(posedge clk_tx); #1;
            if (i == 0) begin
                total++; if (u_tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy_rise got=%b want=1", u_tx_busy); end
                total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_popped got=%0d want=0", fifo_count); end
            end
            total++;
            if (u_tx !== exp[i]) begin
                bad++; $display("FAIL single_bit%0d got=%b want=%b", i, u_tx, exp[i]);
            end
            if (u_tx_done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL single_early_done got=%0d want=0", dones); end
        @(posedge clk_tx); #1;
        total++; if (u_tx_done !== 1'b1) begin bad++; $display("FAIL single_done got=%b want=1", u_tx_done); end
        total++; if (u_tx_busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", u_tx_busy); end
        total++; if (u_tx !== 1'b1) begin bad++; $display("FAIL single_line_high got=%b want=1", u_tx); end
        @(posedge clk_tx); #1;
        total++; if (u_tx_done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%b want=0", u_tx_done); end
    endtask

    // Bench-side deserialiser stands in for the receiver on the same clock.
    task automatic test_loopback();
        logic [32:0] stream, exp;
        int          dones;
        logic        ready_low;
        exp       = {1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
        dones     = 0;
        ready_low = 1'b0;
        en_tx     = 1'b1;
        tx_data   = 8'h01;
        tx_valid  = 1'b1;
        @(posedge clk_tx); #1;
        tx_data = 8'hFF;
        for (int i = 0; i < 34; i++) begin
            @(posedge clk_tx); #1;
            if (i == 0) tx_data = 8'h3C;
            if (i == 1) tx_valid = 1'b0;
            if (i < 33) stream[i] = u_tx;
            if (u_tx_done === 1'b1) dones++;
            if (tx_ready !== 1'b1) ready_low = 1'b1;
        end
        total++; if (stream[8:1] !== 8'h01) begin bad++; $display("FAIL loop_byte0 got=%h want=01", stream[8:1]); end
        total++; if (stream[9] !== 1'b1) begin bad++; $display("FAIL loop_parity0 got=%b want=1", stream[9]); end
        total++; if (stream[19:12] !== 8'hFF) begin bad++; $display("FAIL loop_byte1 got=%h want=ff", stream[19:12]); end
        total++; if (stream[30:23] !== 8'h3C) begin bad++; $display("FAIL loop_byte2 got=%h want=3c", stream[30:23]); end
        total++; if (stream !== exp) begin bad++; $display("FAIL loop_stream got=%h want=%h", stream, exp); end
        total++; if (dones != 3) begin bad++; $display("FAIL loop_dones got=%0d want=3", dones); end
        total++; if (ready_low !== 1'b0) begin bad++; $display("FAIL loop_ready got=%b want=0", ready_low); end
        total++; if (u_tx_busy !== 1'b0) begin bad++; $display("FAIL loop_idle got=%b want=0", u_tx_busy); end
    endtask

    task automatic test_full_fifo();
        logic [43:0] stream, exp;
        int          dones;
        exp   = {1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0,
                 1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
        dones = 0;
        en_tx    = 1'b0;
        tx_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tx_data = full_bytes[k];
            @(posedge clk_tx); #1;
            total++;
            if (fifo_count !== full_cnt[k]) begin
                bad++; $display("FAIL full_count%0d got=%0d want=%0d", k, fifo_count, full_cnt[k]);
            end
            total++;
            if (tx_ready !== full_rdy[k]) begin
                bad++; $display("FAIL full_ready%0d got=%b want=%b", k, tx_ready, full_rdy[k]);
            end
        end
        tx_valid = 1'b0;
        total++; if (u_tx_busy !== 1'b0) begin bad++; $display("FAIL full_no_start got=%b want=0", u_tx_busy); end
        en_tx = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk_tx); #1;
            if (i == 0) begin
                total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL full_first_pop got=%0d want=3", fifo_count); end
                total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back got=%b want=1", tx_ready); end
            end
            if (i < 44) stream[i] = u_tx;
            if (u_tx_done === 1'b1) dones++;
        end
        total++; if (stream !== exp) begin bad++; $display("FAIL full_stream got=%h want=%h", stream, exp); end
        total++; if (dones != 4) begin bad++; $display("FAIL full_dones got=%0d want=4", dones); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL full_drained got=%0d want=0", fifo_count); end
    endtask

    task automatic test_en_drop();
        int stray;
        stray    = 0;
        en_tx    = 1'b1;
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        @(posedge clk_tx); #1;
        tx_data = 8'hE7;
        @(posedge clk_tx); #1;
        tx_valid = 1'b0;
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL endrop_queued got=%0d want=1", fifo_count); end
        repeat (9) @(posedge clk_tx);
        #1;
        total++; if (u_tx !== 1'b0) begin bad++; $display("FAIL endrop_parity got=%b want=0", u_tx); end
        en_tx = 1'b0;
        @(posedge clk_tx); #1;
        total++; if (u_tx !== 1'b1) begin bad++; $display("FAIL endrop_stop got=%b want=1", u_tx); end
        @(posedge clk_tx); #1;
        total++; if (u_tx_done !== 1'b1) begin bad++; $display("FAIL endrop_done got=%b want=1", u_tx_done); end
        total++; if (u_tx_busy !== 1'b0) begin bad++; $display("FAIL endrop_idle got=%b want=0", u_tx_busy); end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL endrop_kept got=%0d want=1", fifo_count); end
        repeat (5) begin
            @(posedge clk_tx); #1;
            if (u_tx !== 1'b1 || u_tx_busy !== 1'b0 || fifo_count !== 3'd1) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL endrop_hold got=%0d want=0", stray); end
        en_tx = 1'b1;
        @(posedge clk_tx); #1;
        total++; if (u_tx !== 1'b0) begin bad++; $display("FAIL endrop_restart got=%b want=0", u_tx); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL endrop_pop got=%0d want=0", fifo_count); end
        repeat (12) @(posedge clk_tx);
        #1;
        total++; if (u_tx_busy !== 1'b0) begin bad++; $display("FAIL endrop_finish got=%b want=0", u_tx_busy); end
    endtask

    task automatic test_reset_mid_frame();
        int stray;
        stray    = 0;
        en_tx    = 1'b1;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(posedge clk_tx); #1;
        tx_data = 8'h5A;
        @(posedge clk_tx); #1;
        tx_data = 8'h96;
        @(posedge clk_tx); #1;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk_tx);
        #1;
        total++; if (u_tx !== 1'b0) begin bad++; $display("FAIL rstmid_bit3 got=%b want=0", u_tx); end
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL rstmid_queued got=%0d want=2", fifo_count); end
        rst_tx_n = 1'b0;
        @(posedge clk_tx); #1;
        total++; if (u_tx !== 1'b1) begin bad++; $display("FAIL rstmid_line got=%b want=1", u_tx); end
        total++; if (u_tx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", u_tx_busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rstmid_flush got=%0d want=0", fifo_count); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", tx_ready); end
        rst_tx_n = 1'b1;
        repeat (15) begin
            @(posedge clk_tx); #1;
            if (u_tx !== 1'b1 || u_tx_busy !== 1'b0) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rstmid_no_frame got=%0d want=0", stray); end
    endtask

    task automatic test_slow_baud();
        logic [11:0] exp;
        int          busy_cycles;
        exp         = {1'b1, 1'b1, 1'b1, 8'h80, 1'b0};
        busy_cycles = 0;
        s_en    = 1'b1;
        s_data  = 8'h80;
        s_valid = 1'b1;
        @(posedge clk_tx); #1;
        s_valid = 1'b0;
        for (int k = 0; k < 49; k++) begin
            @(posedge clk_tx); #1;
            if (s_busy === 1'b1) busy_cycles++;
            if (k < 48) begin
                total++;
                if (s_tx !== exp[k/4]) begin
                    bad++; $display("FAIL slow_bit_cycle%0d got=%b want=%b", k, s_tx, exp[k/4]);
                end
                total++;
                if (s_done !== 1'b0) begin
                    bad++; $display("FAIL slow_early_done_cycle%0d got=%b want=0", k, s_done);
                end
            end
        end
        total++; if (s_done !== 1'b1) begin bad++; $display("FAIL slow_done got=%b want=1", s_done); end
        total++; if (busy_cycles != 48) begin bad++; $display("FAIL slow_frame_len got=%0d want=48", busy_cycles); end
        total++; if (s_count !== 3'd0) begin bad++; $display("FAIL slow_count got=%0d want=0", s_count); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_loopback();
        test_full_fifo();
        test_en_drop();
        test_reset_mid_frame();
        test_slow_baud();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
